// File: rtl/agc_mem_pkg.sv
// -----------------------------------------------------------------------------
// agc_mem_pkg
// Shared types and constants for the AGC memory requester slice:
//   - state_t    : requester FSM states
//   - edit_op_t  : offsets of the four editing addresses from EDIT_BASE
//   - SHADOW_WORDS: size of the register-shadow window (addresses 0..8)
//   - EB_W/FB_W/SB_W: bank register field widths
// Used by agc_mem_requester and agc_edit_unit (AGC_EDIT_EN builds only).
// -----------------------------------------------------------------------------
package agc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    EDIT_CYR  = 2'd0,  // rotate right 1
    EDIT_SR   = 2'd1,  // arithmetic shift right 1
    EDIT_CYL  = 2'd2,  // rotate left 1
    EDIT_EDOP = 2'd3   // logical shift right 7
  } edit_op_t;

  // Memory rewrites the central-register shadow words every clock.
  localparam int SHADOW_WORDS = 9;

  localparam int EB_W = 3;
  localparam int FB_W = 5;
  localparam int SB_W = 1;

endpackage

// File: rtl/agc_edit_unit.sv
// -----------------------------------------------------------------------------
// agc_edit_unit
// Combinational editing transform applied to write data aimed at the four
// editing addresses EDIT_BASE+0..+3 (CYR, SR, CYL, EDOP). Any other address
// passes the data through unchanged. Instantiated only when AGC_EDIT_EN is
// defined.
// Ports:
//   addr    in  12  target address of the write
//   dataIn  in  16  raw write data
//   dataOut out 16  data to present on the memory port
// -----------------------------------------------------------------------------
module agc_edit_unit
  import agc_mem_pkg::*;
#(
  parameter logic [11:0] EDIT_BASE = 12'o020
) (
  input  logic [11:0] addr,
  input  logic [15:0] dataIn,
  output logic [15:0] dataOut
);

  // Addresses below EDIT_BASE wrap to large offsets, so one compare covers both ends.
  logic [11:0] offset;
  assign offset = addr - EDIT_BASE;

  always_comb begin
    // NOTE: default first so every path assigns dataOut; otherwise a latch is inferred.
    dataOut = dataIn;
    if (offset < 12'd4) begin
      unique case (edit_op_t'(offset[1:0]))
        EDIT_CYR:  dataOut = {dataIn[0], dataIn[15:1]};
        EDIT_SR:   dataOut = {dataIn[15], dataIn[15:1]};
        EDIT_CYL:  dataOut = {dataIn[14:0], dataIn[15]};
        EDIT_EDOP: dataOut = dataIn >> 7;
      endcase
    end
  end

endmodule

// File: rtl/agc_mem_requester.sv
// -----------------------------------------------------------------------------
// agc_mem_requester
// Initiator side of the AGC banked-memory interface. Accepts one word
// read/write request at a time, snapshots the bank registers at accept, drives
// the memory port and returns a one-cycle response.
//   read          : IDLE -> ADDR -> RESP           (memResult captured in ADDR)
//   write         : IDLE -> ADDR -> WRITE -> RESP  (writeEnable only in WRITE)
//   shadow write  : IDLE -> ADDR -> RESP, rsp_err=1, nothing written
// Optional feature macro: AGC_EDIT_EN -- when defined, writes to
// EDIT_BASE+0..+3 pass through agc_edit_unit before reaching dataIn.
// Ports:
//   clk, reset (async, active-high)
//   req_valid/req_ready/req_write/req_addr/req_wdata : request handshake
//   bank_we/bank_eb/bank_fb/bank_super               : bank register load
//   rsp_valid/rsp_rdata/rsp_err                      : response strobe + data
//   eBank/fBank/superBank/memAddress/dataIn/writeEnable : memory port (out)
//   memResult                                        : memory read data (in)
// -----------------------------------------------------------------------------
module agc_mem_requester
  import agc_mem_pkg::*;
#(
  parameter logic [11:0] SHADOW_TOP = 12'(SHADOW_WORDS - 1)
`ifdef AGC_EDIT_EN
  ,
  parameter logic [11:0] EDIT_BASE = 12'o020
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [11:0]     req_addr,
  input  logic [15:0]     req_wdata,
  input  logic            bank_we,
  input  logic [EB_W-1:0] bank_eb,
  input  logic [FB_W-1:0] bank_fb,
  input  logic [SB_W-1:0] bank_super,
  output logic            rsp_valid,
  output logic [15:0]     rsp_rdata,
  output logic            rsp_err,
  output logic [EB_W-1:0] eBank,
  output logic [FB_W-1:0] fBank,
  output logic [SB_W-1:0] superBank,
  output logic [11:0]     memAddress,
  output logic [15:0]     dataIn,
  output logic            writeEnable,
  input  logic [15:0]     memResult
);

  state_t          state;
  logic [EB_W-1:0] ebReg;
  logic [FB_W-1:0] fbReg;
  logic [SB_W-1:0] sbReg;
  logic            wrFlag;
  logic [15:0]     wdataReg;
  logic [15:0]     editedData;
  logic            shadowHit;

  // memAddress and the bank outputs double as the latched request address and
  // bank snapshot: they change only at accept, so they hold through IDLE.
  assign shadowHit = (memAddress <= SHADOW_TOP);

  // Gated by reset so ready is low during reset and high as soon as it drops.
  assign req_ready = (state == IDLE) && !reset;

`ifdef AGC_EDIT_EN
  agc_edit_unit #(
    .EDIT_BASE(EDIT_BASE)
  ) u_edit (
    .addr   (memAddress),
    .dataIn (wdataReg),
    .dataOut(editedData)
  );
`else
  assign editedData = wdataReg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ebReg       <= '0;
      fbReg       <= '0;
      sbReg       <= '0;
      wrFlag      <= 1'b0;
      wdataReg    <= '0;
      eBank       <= '0;
      fBank       <= '0;
      superBank   <= '0;
      memAddress  <= '0;
      dataIn      <= '0;
      writeEnable <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make these one-cycle strobes; a later
      // assignment in the case below overrides them for this edge only.
      rsp_valid   <= 1'b0;
      writeEnable <= 1'b0;

      // Bank loads never disturb an in-flight request, which uses its snapshot.
      if (bank_we) begin
        ebReg <= bank_eb;
        fbReg <= bank_fb;
        sbReg <= bank_super;
      end

      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wrFlag     <= req_write;
            wdataReg   <= req_wdata;
            memAddress <= req_addr;
            eBank      <= ebReg;   // pre-load value even if bank_we is high now
            fBank      <= fbReg;
            superBank  <= sbReg;
            state      <= ADDR;
          end
        end

        ADDR: begin
          if (!wrFlag) begin
            rsp_rdata <= memResult;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (shadowHit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            dataIn      <= editedData;
            writeEnable <= 1'b1;
            state       <= WRITE;
          end
        end

        WRITE: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end

        RESP: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_mem_requester.sv
// -----------------------------------------------------------------------------
// tb_agc_mem_requester
// Self-checking bench for agc_mem_requester. A behavioural memory returns a
// pattern derived from address and bank outputs; expected responses are pushed
// to a scoreboard queue when a request is driven and popped when rsp_valid
// appears. Latency is counted in clock edges including the accept edge
// (read 2, write 3, refused write 2). Compile with +define+AGC_EDIT_EN to
// exercise the editing transform.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_agc_mem_requester;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [11:0] req_addr;
  logic [15:0] req_wdata;
  logic        bank_we;
  logic [2:0]  bank_eb;
  logic [4:0]  bank_fb;
  logic        bank_super;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  eBank;
  logic [4:0]  fBank;
  logic        superBank;
  logic [11:0] memAddress;
  logic [15:0] dataIn;
  logic        writeEnable;
  logic [15:0] memResult;

  int   tests = 0;
  int   fails = 0;
  rsp_t sbq[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_model(input logic [11:0] a, input logic [2:0] eb,
                                            input logic [4:0] fb, input logic sb);
    return {a[8:0], 7'h00} ^ {eb, fb, sb, 7'h55};
  endfunction

  assign memResult = mem_model(memAddress, eBank, fBank, superBank);

  agc_mem_requester dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .bank_we    (bank_we),
    .bank_eb    (bank_eb),
    .bank_fb    (bank_fb),
    .bank_super (bank_super),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .eBank      (eBank),
    .fBank      (fBank),
    .superBank  (superBank),
    .memAddress (memAddress),
    .dataIn     (dataIn),
    .writeEnable(writeEnable),
    .memResult  (memResult)
  );

  task automatic load_banks(input logic [2:0] eb, input logic [4:0] fb, input logic sb);
    @(negedge clk);
    bank_we = 1'b1; bank_eb = eb; bank_fb = fb; bank_super = sb;
    @(posedge clk);
    #1 bank_we = 1'b0;
  endtask

  // One full request. bw/nEb load a new EB in the accept cycle itself.
  task automatic do_req(input string name, input logic wr, input logic [11:0] a,
                        input logic [15:0] d, input logic [2:0] xEb, input logic [4:0] xFb,
                        input logic xSb, input int expLat, input logic expErr,
                        input logic [15:0] expData, input logic bw, input logic [2:0] nEb);
    rsp_t        e, got;
    int          lat, weCnt;
    logic [15:0] weData;
    bit          seen;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL %s ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    if (bw) begin bank_we = 1'b1; bank_eb = nEb; end
    e.rdata = wr ? 16'h0000 : mem_model(a, xEb, xFb, xSb);
    e.err   = expErr;
    sbq.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0; bank_we = 1'b0;
    lat = 1; weCnt = 0; weData = '0; seen = 0;
    @(negedge clk);
    tests++;
    if (memAddress !== a || writeEnable !== 1'b0) begin
      fails++; $display("FAIL %s addr: got %o we=%b want %o we=0", name, memAddress, writeEnable, a);
    end
    tests++;
    if ({eBank, fBank, superBank} !== {xEb, xFb, xSb}) begin
      fails++; $display("FAIL %s banks: got eb=%0d fb=%0d sb=%0d want eb=%0d fb=%0d sb=%0d",
                        name, eBank, fBank, superBank, xEb, xFb, xSb);
    end
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid === 1'b1) begin seen = 1; break; end
      if (writeEnable === 1'b1) begin weCnt++; weData = dataIn; end
      @(posedge clk); lat++;
      @(negedge clk);
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL %s timeout: rsp_valid never seen within 8 cycles", name);
      void'(sbq.pop_front());
    end else begin
      got = sbq.pop_front();
      if (lat != expLat || rsp_rdata !== got.rdata || rsp_err !== got.err || req_ready !== 1'b0) begin
        fails++; $display("FAIL %s rsp: got lat=%0d rdata=%h err=%b ready=%b want lat=%0d rdata=%h err=%b ready=0",
                          name, lat, rsp_rdata, rsp_err, req_ready, expLat, got.rdata, got.err);
      end
    end
    tests++;
    if (weCnt != ((wr && !expErr) ? 1 : 0) || (weCnt == 1 && weData !== expData)) begin
      fails++; $display("FAIL %s write: got pulses=%0d data=%h want pulses=%0d data=%h",
                        name, weCnt, weData, (wr && !expErr) ? 1 : 0, expData);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    bank_we = 0; bank_eb = '0; bank_fb = '0; bank_super = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready_held: got %b want 0", req_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_rdata, rsp_err, eBank, fBank, superBank, memAddress, dataIn, writeEnable} !== '0) begin
      fails++; $display("FAIL reset_outputs: got rv=%b rd=%h err=%b eb=%0d fb=%0d sb=%b a=%o d=%h we=%b want all 0",
                        rsp_valid, rsp_rdata, rsp_err, eBank, fBank, superBank, memAddress, dataIn, writeEnable);
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready_release: got %b want 1", req_ready);
    end
  endtask

  task automatic test_read();
    load_banks(3'd3, 5'd5, 1'b0);
    do_req("read_1400", 1'b0, 12'o1400, 16'h0, 3'd3, 5'd5, 1'b0, 2, 1'b0, 16'h0, 1'b0, 3'd0);
    load_banks(3'd6, 5'd17, 1'b1);
    do_req("read_7777", 1'b0, 12'o7777, 16'h0, 3'd6, 5'd17, 1'b1, 2, 1'b0, 16'h0, 1'b0, 3'd0);
  endtask

  task automatic test_write();
    do_req("write_0100", 1'b1, 12'o0100, 16'h1234, 3'd6, 5'd17, 1'b1, 3, 1'b0, 16'h1234, 1'b0, 3'd0);
  endtask

  task automatic test_shadow();
    do_req("write_5",  1'b1, 12'd5, 16'hBEEF, 3'd6, 5'd17, 1'b1, 2, 1'b1, 16'h0, 1'b0, 3'd0);
    do_req("write_8",  1'b1, 12'd8, 16'h5A5A, 3'd6, 5'd17, 1'b1, 2, 1'b1, 16'h0, 1'b0, 3'd0);
    do_req("write_9",  1'b1, 12'd9, 16'hA5A5, 3'd6, 5'd17, 1'b1, 3, 1'b0, 16'hA5A5, 1'b0, 3'd0);
  endtask

  task automatic test_bank_same_cycle();
    load_banks(3'd2, 5'd9, 1'b0);
    do_req("bank_old", 1'b0, 12'o2000, 16'h0, 3'd2, 5'd9, 1'b0, 2, 1'b0, 16'h0, 1'b1, 3'd7);
    do_req("bank_new", 1'b0, 12'o2001, 16'h0, 3'd7, 5'd9, 1'b0, 2, 1'b0, 16'h0, 1'b0, 3'd0);
  endtask

  task automatic test_edit();
    logic [15:0] x0, x1, x2, x3;
`ifdef AGC_EDIT_EN
    x0 = 16'hC000; x1 = 16'hC000; x2 = 16'h0003; x3 = 16'h0100;
`else
    x0 = 16'h8001; x1 = 16'h8001; x2 = 16'h8001; x3 = 16'h8001;
`endif
    do_req("edit_cyr",  1'b1, 12'o020, 16'h8001, 3'd7, 5'd9, 1'b0, 3, 1'b0, x0, 1'b0, 3'd0);
    do_req("edit_sr",   1'b1, 12'o021, 16'h8001, 3'd7, 5'd9, 1'b0, 3, 1'b0, x1, 1'b0, 3'd0);
    do_req("edit_cyl",  1'b1, 12'o022, 16'h8001, 3'd7, 5'd9, 1'b0, 3, 1'b0, x2, 1'b0, 3'd0);
    do_req("edit_edop", 1'b1, 12'o023, 16'h8001, 3'd7, 5'd9, 1'b0, 3, 1'b0, x3, 1'b0, 3'd0);
    do_req("edit_none", 1'b1, 12'o024, 16'h8001, 3'd7, 5'd9, 1'b0, 3, 1'b0, 16'h8001, 1'b0, 3'd0);
  endtask

  task automatic test_reset_mid_write();
    bit sawRsp;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'o0200; req_wdata = 16'hABCD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);                  // ADDR
    @(negedge clk);                  // WRITE
    tests++;
    if (writeEnable !== 1'b1) begin
      fails++; $display("FAIL abort_pre_we: got %b want 1", writeEnable);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (writeEnable !== 1'b0 || rsp_valid !== 1'b0 || memAddress !== 12'o0) begin
      fails++; $display("FAIL abort_async: got we=%b rv=%b a=%o want we=0 rv=0 a=0",
                        writeEnable, rsp_valid, memAddress);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sawRsp = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || writeEnable !== 1'b0) sawRsp = 1;
    end
    tests++;
    if (sawRsp || req_ready !== 1'b1) begin
      fails++; $display("FAIL abort_no_rsp: got stray=%b ready=%b want stray=0 ready=1", sawRsp, req_ready);
    end
    do_req("post_abort", 1'b0, 12'o3000, 16'h0, 3'd0, 5'd0, 1'b0, 2, 1'b0, 16'h0, 1'b0, 3'd0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_shadow();
    test_bank_same_cycle();
    test_edit();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/agc_mem_requester.md
Name: agc_mem_requester

Overview:
- Initiator side of the AGC memory interface. Accepts word read/write requests from the CPU sequencer, holds the bank registers (EB, FB, super-bank), drives the banked memory port and returns read data.
- Sits between the control unit and the banked memory. It is the only driver of eBank/fBank/superBank/memAddress/dataIn/writeEnable.

Parameters:
- SHADOW_TOP, 8: highest address of the register-shadow window (0..SHADOW_TOP). Memory overwrites these words every clock, so writes there are refused.
- EDIT_BASE, 12'o020: first of four editing addresses (CYR, SR, CYL, EDOP); used only with AGC_EDIT_EN.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  requester can accept a request
- req_write  input  1  1 = write, 0 = read
- req_addr  input  12  S-register address
- req_wdata  input  16  write data
- bank_we  input  1  load bank registers
- bank_eb  input  3  new EB value
- bank_fb  input  5  new FB value
- bank_super  input  1  new super-bank bit
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  16  read data, valid with rsp_valid
- rsp_err  output  1  write refused, valid with rsp_valid
- eBank  output  3  to memory
- fBank  output  5  to memory
- superBank  output  1  to memory
- memAddress  output  12  to memory
- dataIn  output  16  to memory
- writeEnable  output  1  to memory
- memResult  input  16  memory combinational read data

Behaviour:
- Reset (async, active-high) clears everything:
  - State goes to IDLE.
  - Bank registers, all memory-port outputs, rsp_rdata, rsp_valid and rsp_err go to 0.
  - req_ready = 0 while reset is asserted, 1 in the first cycle after release.
- States are IDLE, ADDR, WRITE, RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid is high, the request is latched: write flag, address, data, plus a snapshot of the current bank registers. Next state is ADDR.
- ADDR:
  - memAddress and the bank outputs are driven from the latched values. writeEnable = 0.
  - Read: memResult is captured into rsp_rdata at the end of the cycle, then go to RESP.
  - Write to an address at or below SHADOW_TOP: no write is issued. rsp_err is set and the state goes to RESP.
  - Any other write: go to WRITE.
- WRITE:
  - writeEnable = 1 for exactly one cycle. dataIn = latched data, transformed if AGC_EDIT_EN is defined.
  - Next state is RESP.
- RESP:
  - rsp_valid = 1 for one cycle; rsp_rdata and rsp_err are valid.
  - rsp_rdata = 0 for writes.
  - Next state is IDLE. req_ready = 0 here, so requests are never back-to-back without an IDLE cycle.
- Latency from accept edge to rsp_valid: 2 cycles for a read, 3 for a write, 2 for a refused write.
- writeEnable is never asserted outside WRITE. Memory-port outputs hold their last values in IDLE.
- Bank registers:
  - bank_we loads them in any state.
  - A request in flight always uses its snapshot.
  - bank_we in the same cycle as an accept: the request uses the old banks, and the new values apply from the next request.
- Reset mid-operation aborts the transfer. writeEnable drops immediately (async) and no response is issued.

Optional Feature:
- Macro: AGC_EDIT_EN.
- Defined: writes to EDIT_BASE+0..+3 are transformed before dataIn:
  - CYR: rotate right 1 (16-bit).
  - SR: arithmetic shift right 1 (bit 15 kept).
  - CYL: rotate left 1.
  - EDOP: logical shift right 7.
- Undefined: the data is written unchanged.
- Reads are unaffected either way.

Decomposition:
- Shared package agc_mem_pkg holds:
  - the state enum;
  - constants for EDIT_BASE offsets (CYR=0, SR=1, CYL=2, EDOP=3);
  - the shadow-window size;
  - bank field widths (3, 5, 1).
- One natural sub-module, agc_edit_unit: combinational editing transform of address offset and data, instantiated only under AGC_EDIT_EN.

Test Plan:
- Reset held 3 cycles then released → all outputs 0; req_ready = 1 on the first cycle after release.
- bank_we with EB=3, FB=5, super=0, then read 12'o1400 → eBank=3, fBank=5, memAddress=12'o1400 in ADDR; rsp_valid 2 cycles after accept with rsp_rdata equal to memResult.
- Write 16'h1234 to 12'o0100 → writeEnable high exactly 1 cycle with dataIn=16'h1234; rsp_valid 3 cycles after accept, rsp_err=0.
- Write to address 5 → writeEnable never rises; rsp_valid with rsp_err=1 two cycles after accept.
- bank_we EB=7 in the same cycle as a read accept with old EB=2 → that read drives eBank=2; the following read drives eBank=7.
- With AGC_EDIT_EN: write 16'h8001 to 12'o020 → dataIn=16'hC000. Write 16'h8001 to 12'o021 → dataIn=16'hC000. Without the macro → dataIn=16'h8001. Reset during WRITE → writeEnable low at once, no rsp_valid.
